// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder: upstream feeder for an N x N weight-stationary
// systolic array. Takes one weight matrix per job and a stream of N-element
// vectors, buffers vectors in a small FIFO, skews them diagonally (lane i
// delayed i cycles), drains N-1 zero cycles after the last vector and then
// pulses job_done.
// Optional build macro: FEEDER_STALL_CNT_EN adds the stall_cycles output
// (STREAM cycles spent with an empty FIFO).
module systolic_input_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [N*N*DATA_WIDTH-1:0]    w_data,
    input  logic                         vec_valid,
    output logic                         vec_ready,
    input  logic [N*DATA_WIDTH-1:0]      vec_data,
    input  logic                         vec_last,
    output logic                         array_load_weights,
    output logic [N*N*DATA_WIDTH-1:0]    array_w_in,
    output logic                         array_start,
    output logic [N*DATA_WIDTH-1:0]      array_x_in,
    output logic                         busy,
    output logic [15:0]                  vec_count,
    output logic                         job_done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                  stall_cycles
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int DRAIN_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t               state, state_next;
    logic [DRAIN_W-1:0]   drain_cnt, drain_next;
    logic                 finish;
    logic                 last_seen;

    logic [N*DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop;
    logic [N*DATA_WIDTH-1:0] pop_data;
    logic                    pop_last;
    logic                    load_entry;
    logic [N-1:0]            lane_valid;

    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign vec_ready  = !fifo_full && !last_seen;
    assign push       = vec_valid && vec_ready;
    assign pop        = (state == STREAM) && !fifo_empty;
    assign pop_data   = fifo_data[rd_ptr];
    assign pop_last   = fifo_last[rd_ptr];
    assign load_entry = (state == IDLE) && w_valid;

    // Next-state, drain counter and Moore outputs of the job FSM.
    always_comb begin
        state_next         = state;
        drain_next         = drain_cnt;
        finish             = 1'b0;
        w_ready            = (state == IDLE);
        busy               = (state != IDLE);
        array_load_weights = (state == LOAD_W);
        case (state)
            IDLE: begin
                if (w_valid) state_next = LOAD_W;
            end
            LOAD_W: begin
                state_next = STREAM;
            end
            STREAM: begin
                if (pop && pop_last) begin
                    if (N == 1) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end else begin
                        state_next = DRAIN;
                        drain_next = DRAIN_W'(N - 1);
                    end
                end
            end
            DRAIN: begin
                drain_next = drain_cnt - DRAIN_W'(1);
                if (drain_next == '0) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, drain counter, job_done pulse and last-vector gate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            job_done  <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            job_done  <= finish;
            if (finish)
                last_seen <= 1'b0;
            else if (push && vec_last)
                last_seen <= 1'b1;
        end
    end

    // Weight capture on handshake; held stable for the whole job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            array_w_in <= '0;
        else if (load_entry)
            array_w_in <= w_data;
    end

    // FIFO storage; contents need no reset because pointers are flushed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= vec_data;
            fifo_last[wr_ptr] <= vec_last;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Popped-vector counter, cleared when a new job's weights are taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vec_count <= '0;
        else if (load_entry)
            vec_count <= '0;
        else if (pop && (vec_count != 16'hFFFF))
            vec_count <= vec_count + 16'd1;
    end

`ifdef FEEDER_STALL_CNT_EN
    // Bubble counter: STREAM cycles with nothing to pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (load_entry)
            stall_cycles <= '0;
        else if ((state == STREAM) && fifo_empty && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] d_q [0:gi];
            logic                  v_q [0:gi];

            // Lane gi delay line: gi+1 stages, bubbles enter as zero/invalid.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned s = 0; s <= gi; s++) begin
                        d_q[s] <= '0;
                        v_q[s] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= pop ? pop_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                    v_q[0] <= pop;
                    for (int unsigned s = 1; s <= gi; s++) begin
                        d_q[s] <= d_q[s-1];
                        v_q[s] <= v_q[s-1];
                    end
                end
            end

            assign array_x_in[gi*DATA_WIDTH +: DATA_WIDTH] = v_q[gi] ? d_q[gi] : '0;
            assign lane_valid[gi] = v_q[gi];
        end
    endgenerate

    assign array_start = |lane_valid;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder (N=4, DATA_WIDTH=16, FIFO_DEPTH=4).
// Basic job is table-driven cycle by cycle; prefetch/full, bubbles, last
// gating, mid-job reset and single-vector jobs are hand-written sequences.
module tb_systolic_input_feeder;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int XW = N*DW;
    localparam int WW = N*N*DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          w_valid, w_ready;
    logic [WW-1:0] w_data;
    logic          vec_valid, vec_ready, vec_last;
    logic [XW-1:0] vec_data;
    logic          array_load_weights, array_start, busy, job_done;
    logic [WW-1:0] array_w_in;
    logic [XW-1:0] array_x_in;
    logic [15:0]   vec_count;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    systolic_input_feeder #(.DATA_WIDTH(DW), .N(N), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_data(w_data),
        .vec_valid(vec_valid),
        .vec_ready(vec_ready),
        .vec_data(vec_data),
        .vec_last(vec_last),
        .array_load_weights(array_load_weights),
        .array_w_in(array_w_in),
        .array_start(array_start),
        .array_x_in(array_x_in),
        .busy(busy),
        .vec_count(vec_count),
        .job_done(job_done)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Vector k: element i = k*N + i + 1 (k=0 -> 1,2,3,4; k=1 -> 5,6,7,8).
    function automatic logic [XW-1:0] mkv(input int k);
        logic [XW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(k*N + i + 1);
        return r;
    endfunction

    // Weight matrix: element (i,j) = base + i*N + j.
    function automatic logic [WW-1:0] mkw(input int base);
        logic [WW-1:0] r;
        for (int i = 0; i < N*N; i++) r[i*DW +: DW] = DW'(base + i);
        return r;
    endfunction

    function automatic logic [XW-1:0] ln(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    typedef struct {
        logic          w_valid;
        logic          vec_valid;
        logic          vec_last;
        int            vec_k;
        logic [XW-1:0] exp_x;
        logic          exp_start;
        logic          exp_load;
        logic          exp_busy;
        logic          exp_done;
        logic          exp_vready;
        logic          exp_wready;
    } row_t;

    function automatic row_t mkrow(input logic wv, input logic vv, input logic vl, input int k,
                                   input logic [XW-1:0] x, input logic st, input logic ld,
                                   input logic bz, input logic dn, input logic vr, input logic wr);
        row_t r;
        r.w_valid = wv; r.vec_valid = vv; r.vec_last = vl; r.vec_k = k;
        r.exp_x = x; r.exp_start = st; r.exp_load = ld; r.exp_busy = bz;
        r.exp_done = dn; r.exp_vready = vr; r.exp_wready = wr;
        return r;
    endfunction

    // Per-cycle trace, sampled 1 time unit after each falling edge.
    logic          mon_en = 1'b0;
    logic [DW-1:0] tr_l0[$];
    logic [DW-1:0] tr_l3[$];
    logic          tr_start[$];
    logic          tr_busy[$];
    int            done_cnt;

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            tr_l0.push_back(array_x_in[0 +: DW]);
            tr_l3.push_back(array_x_in[3*DW +: DW]);
            tr_start.push_back(array_start);
            tr_busy.push_back(busy);
            if (job_done) done_cnt++;
        end
    end

    task automatic mon_start();
        tr_l0.delete(); tr_l3.delete(); tr_start.delete(); tr_busy.delete();
        done_cnt = 0;
        mon_en = 1'b1;
    endtask

    task automatic push_vec(input int k, input logic last);
        int t = 0;
        vec_valid = 1'b1; vec_data = mkv(k); vec_last = last;
        while (vec_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        if (t >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL push_vec_timeout k=%0d: vec_ready=%b, required 1", k, vec_ready);
        end
        @(negedge clk);
        vec_valid = 1'b0; vec_last = 1'b0;
    endtask

    task automatic send_w(input int base);
        int t = 0;
        w_valid = 1'b1; w_data = mkw(base);
        while (w_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        if (t >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL send_w_timeout: w_ready=%b, required 1", w_ready);
        end
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (job_done !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        if (t >= 60) begin
            n_cmp++; n_bad++;
            $display("FAIL job_done_timeout: job_done=%b, required 1", job_done);
        end
        @(negedge clk);
        mon_en = 1'b0;
    endtask

    // Nonzero values seen on lane 0 or 3 must be vectors first_k.. in order.
    task automatic check_seq(input string name, input int lane, input int first_k, input int num);
        logic [DW-1:0] nz[$];
        if (lane == 0) begin
            foreach (tr_l0[i]) if (tr_l0[i] != '0) nz.push_back(tr_l0[i]);
        end else begin
            foreach (tr_l3[i]) if (tr_l3[i] != '0) nz.push_back(tr_l3[i]);
        end
        chk($sformatf("%s count", name), WW'(nz.size()), WW'(num));
        for (int i = 0; i < num && i < nz.size(); i++)
            chk($sformatf("%s[%0d]", name, i), WW'(nz[i]), WW'((first_k + i)*N + lane + 1));
    endtask

    function automatic int first_nz();
        foreach (tr_l0[i]) if (tr_l0[i] != '0) return i;
        return -1;
    endfunction

    row_t tbl[9];

    initial begin
        int f;
        int hi;

        // Basic job: weights 1..16, vectors [1,2,3,4] then [5,6,7,8] (last).
        tbl[0] = mkrow(1, 0, 0, 0, '0,             0, 0, 0, 0, 1, 1);
        tbl[1] = mkrow(0, 1, 0, 0, '0,             0, 1, 1, 0, 1, 0);
        tbl[2] = mkrow(0, 1, 1, 1, '0,             0, 0, 1, 0, 1, 0);
        tbl[3] = mkrow(0, 0, 0, 0, ln(1, 0, 0, 0), 1, 0, 1, 0, 0, 0);
        tbl[4] = mkrow(0, 0, 0, 0, ln(5, 2, 0, 0), 1, 0, 1, 0, 0, 0);
        tbl[5] = mkrow(0, 0, 0, 0, ln(0, 6, 3, 0), 1, 0, 1, 0, 0, 0);
        tbl[6] = mkrow(0, 0, 0, 0, ln(0, 0, 7, 4), 1, 0, 1, 0, 0, 0);
        tbl[7] = mkrow(0, 0, 0, 0, ln(0, 0, 0, 8), 1, 0, 0, 1, 1, 1);
        tbl[8] = mkrow(0, 0, 0, 0, '0,             0, 0, 0, 0, 1, 1);

        reset = 1'b1; w_valid = 1'b0; w_data = mkw(1);
        vec_valid = 1'b0; vec_data = '0; vec_last = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst x", array_x_in, '0);
        chk("rst w_in", array_w_in, '0);
        chk("rst start", array_start, 0);
        chk("rst load", array_load_weights, 0);
        chk("rst busy", busy, 0);
        chk("rst done", job_done, 0);
        chk("rst vcount", vec_count, 0);
        chk("rst w_ready", w_ready, 1);
        chk("rst vec_ready", vec_ready, 1);
`ifdef FEEDER_STALL_CNT_EN
        chk("rst stall", stall_cycles, 0);
`endif
        reset = 1'b0;

        for (int r = 0; r < 9; r++) begin
            @(negedge clk);
            chk($sformatf("r%0d x", r), array_x_in, tbl[r].exp_x);
            chk($sformatf("r%0d start", r), array_start, tbl[r].exp_start);
            chk($sformatf("r%0d load", r), array_load_weights, tbl[r].exp_load);
            chk($sformatf("r%0d busy", r), busy, tbl[r].exp_busy);
            chk($sformatf("r%0d done", r), job_done, tbl[r].exp_done);
            chk($sformatf("r%0d vec_ready", r), vec_ready, tbl[r].exp_vready);
            chk($sformatf("r%0d w_ready", r), w_ready, tbl[r].exp_wready);
            w_valid   = tbl[r].w_valid;
            vec_valid = tbl[r].vec_valid;
            vec_last  = tbl[r].vec_last;
            vec_data  = mkv(tbl[r].vec_k);
        end
        chk("basic w_in", array_w_in, mkw(1));
        chk("basic vcount", vec_count, 2);
`ifdef FEEDER_STALL_CNT_EN
        chk("basic stall", stall_cycles, 0);
`endif

        // Prefetch four vectors while IDLE; fifth waits for space.
        @(negedge clk);
        mon_start();
        push_vec(2, 0); push_vec(3, 0); push_vec(4, 0); push_vec(5, 0);
        chk("pf full vec_ready", vec_ready, 0);
        chk("pf idle busy", busy, 0);
        vec_valid = 1'b1; vec_data = mkv(6); vec_last = 1'b1;
        repeat (2) @(negedge clk);
        chk("pf held vec_ready", vec_ready, 0);
        send_w(17);
        push_vec(6, 1);
        wait_done();
        check_seq("pf lane0", 0, 2, 5);
        check_seq("pf lane3", 3, 2, 5);
        chk("pf vcount", vec_count, 5);
        chk("pf done_cnt", done_cnt, 1);
        chk("pf w_in", array_w_in, mkw(17));
`ifdef FEEDER_STALL_CNT_EN
        chk("pf stall", stall_cycles, 0);
`endif

        // Bubbles: two idle cycles between vectors; then last-vector gating.
        mon_start();
        send_w(33);
        push_vec(7, 0);
        repeat (2) @(negedge clk);
        push_vec(8, 1);
        chk("gate busy", busy, 1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("gate vec_ready c%0d", c), vec_ready, 0);
            @(negedge clk);
        end
        chk("gate done", job_done, 1);
        chk("gate idle vec_ready", vec_ready, 1);
        @(negedge clk);
        mon_en = 1'b0;
        f = first_nz();
        if (f < 0 || f + 6 >= tr_l0.size()) begin
            n_cmp++; n_bad++;
            $display("FAIL bub trace: first lane0 index %0d, trace length %0d", f, tr_l0.size());
        end else begin
            chk("bub l0 v7", tr_l0[f], 29);
            chk("bub l0 gap1", tr_l0[f+1], 0);
            chk("bub l0 gap2", tr_l0[f+2], 0);
            chk("bub l0 v8", tr_l0[f+3], 33);
            chk("bub l3 v7", tr_l3[f+3], 32);
            chk("bub l3 gap1", tr_l3[f+4], 0);
            chk("bub l3 gap2", tr_l3[f+5], 0);
            chk("bub l3 v8", tr_l3[f+6], 36);
        end
        hi = 0;
        foreach (tr_start[i]) if (tr_start[i]) hi++;
        chk("bub start cycles", hi, 7);
        chk("bub vcount", vec_count, 2);
`ifdef FEEDER_STALL_CNT_EN
        chk("bub stall", stall_cycles, 2);
`endif

        // Reset in STREAM with two vectors still buffered.
        mon_start();
        push_vec(9, 0); push_vec(10, 0); push_vec(11, 0);
        send_w(49);
        repeat (2) @(negedge clk);
        chk("mid lane0 before reset", array_x_in[0 +: DW], 37);
        reset = 1'b1;
        #1;
        chk("mid rst x", array_x_in, '0);
        chk("mid rst w_in", array_w_in, '0);
        chk("mid rst start", array_start, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst done", job_done, 0);
        chk("mid rst vcount", vec_count, 0);
        chk("mid rst vec_ready", vec_ready, 1);
        chk("mid rst w_ready", w_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid after busy", busy, 0);
        chk("mid after vec_ready", vec_ready, 1);
        chk("mid after x", array_x_in, '0);
        mon_en = 1'b0;
        chk("mid no job_done", done_cnt, 0);

        // Single-vector job; stale entries would show up here if not flushed.
        mon_start();
        push_vec(12, 1);
        chk("single vec_ready gated", vec_ready, 0);
        send_w(65);
        wait_done();
        check_seq("single lane0", 0, 12, 1);
        check_seq("single lane3", 3, 12, 1);
        hi = 0;
        foreach (tr_busy[i]) if (tr_busy[i]) hi++;
        chk("single busy cycles", hi, 5);
        chk("single done_cnt", done_cnt, 1);
        chk("single vcount", vec_count, 1);
`ifdef FEEDER_STALL_CNT_EN
        chk("single stall", stall_cycles, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
